// File: rtl/hash_target_comparator_p.sv
// Full-width hash vs target magnitude comparator: loads a wide target, streams hash words
// LS first, keeps a running LT/EQ/GT verdict and strobes a hit result once per hash.
module hash_target_comparator_p #(
  parameter int HASH_W    = 256,
  parameter int WORD_W    = 64,
  parameter int TGT_W     = 32,
  parameter int BYTE_SWAP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TGT_W-1:0]  target,
  input  logic              target_we,
  input  logic              stop,
  input  logic              cmp_le,
  output logic              hash_re,
  input  logic [WORD_W-1:0] hash_din,
  input  logic              hash_din_we,
  output logic [HASH_W-1:0] hash_dout,
  output logic              hash_rdy,
  output logic              target_loaded,
  output logic              result_valid,
  output logic              result,
  output logic              nonce_fifo_re,
  output logic [31:0]       hashes_done,
  output logic [31:0]       hits
);

  localparam int NT    = HASH_W / TGT_W;
  localparam int NW    = HASH_W / WORD_W;
  localparam int IDX_W = $clog2((NT > NW) ? NT : NW) + 1;

  typedef enum logic [1:0] {INIT, LOAD_TARGET, COLLECT, RESULT} state_t;
  typedef enum logic [1:0] {CMP_EQ, CMP_LT, CMP_GT} cmp_t;

  state_t             state, state_nxt;
  cmp_t               cmp;
  logic [IDX_W-1:0]   idx;
  logic [HASH_W-1:0]  target_reg;
  logic [HASH_W-1:0]  target_shift;
  logic [WORD_W-1:0]  word_sw;
  logic [WORD_W-1:0]  tgt_slice;
  logic               hit;

  generate
    if (BYTE_SWAP != 0) begin : g_swap
      for (genvar b = 0; b < WORD_W / 8; b++) begin : g_byte
        assign word_sw[b*8 +: 8] = hash_din[WORD_W-8-b*8 +: 8];
      end
    end else begin : g_pass
      assign word_sw = hash_din;
    end

    // New target words enter at the top so the first word ends up least significant
    if (NT > 1) begin : g_tshift
      assign target_shift = {target, target_reg[HASH_W-1:TGT_W]};
    end else begin : g_tsingle
      assign target_shift = target;
    end
  endgenerate

  always_comb begin
    tgt_slice = '0;
    for (int i = 0; i < NW; i++) begin
      if (idx == IDX_W'(i)) tgt_slice = target_reg[i*WORD_W +: WORD_W];
    end
  end

  assign hit = (cmp == CMP_LT) | (cmp_le & (cmp == CMP_EQ));

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hash_re   = 1'b0;
    case (state)
      INIT:        state_nxt = LOAD_TARGET;
      LOAD_TARGET: begin
        if (stop)                                       state_nxt = INIT;
        else if (target_we && idx == IDX_W'(NT - 1))    state_nxt = COLLECT;
      end
      COLLECT: begin
        hash_re = ~stop;
        if (stop)                                       state_nxt = INIT;
        else if (hash_din_we && idx == IDX_W'(NW - 1))  state_nxt = RESULT;
      end
      RESULT:      state_nxt = stop ? INIT : COLLECT;
      default:     state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp           <= CMP_EQ;
      idx           <= '0;
      target_reg    <= '0;
      hash_dout     <= '0;
      hash_rdy      <= 1'b0;
      target_loaded <= 1'b0;
      result_valid  <= 1'b0;
      result        <= 1'b0;
      nonce_fifo_re <= 1'b0;
      hashes_done   <= '0;
      hits          <= '0;
    end else begin
      result_valid  <= 1'b0;
      nonce_fifo_re <= 1'b0;
      case (state)
        INIT: begin
          target_reg    <= '0;
          idx           <= '0;
          result        <= 1'b0;
          hashes_done   <= '0;
          hits          <= '0;
          target_loaded <= 1'b0;
          cmp           <= CMP_EQ;
        end
        LOAD_TARGET: begin
          if (!stop && target_we) begin
            target_reg <= target_shift;
            if (idx == IDX_W'(NT - 1)) begin
              idx           <= '0;
              target_loaded <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        COLLECT: begin
          if (!stop && hash_din_we) begin
            for (int i = 0; i < NW; i++) begin
              if (idx == IDX_W'(i)) hash_dout[i*WORD_W +: WORD_W] <= word_sw;
            end
            // Later (more significant) words override; equal words keep the verdict so far
            if (word_sw < tgt_slice)      cmp <= CMP_LT;
            else if (word_sw > tgt_slice) cmp <= CMP_GT;
            if (idx == '0) hash_rdy <= 1'b0;
            if (idx == IDX_W'(NW - 1)) begin
              hash_rdy    <= 1'b1;
              hashes_done <= hashes_done + 32'd1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        RESULT: begin
          if (!stop) begin
            result_valid  <= 1'b1;
            nonce_fifo_re <= 1'b1;
            result        <= hit;
            if (hit) hits <= hits + 32'd1;
            idx           <= '0;
            cmp           <= CMP_EQ;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_target_comparator_p.sv
// Randomised bench for hash_target_comparator_p: two instances (pass-through and byte-swapped)
// checked against a whole-number compare model of the hash and target values.
module tb_hash_target_comparator_p;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  target = '0;
  logic         target_we = 1'b0;
  logic         stop = 1'b0;
  logic         cmp_le = 1'b0;
  logic [63:0]  hash_din = '0;
  logic         hash_din_we = 1'b0;

  logic         hash_re_a, hash_rdy_a, target_loaded_a, result_valid_a, result_a, nonce_fifo_re_a;
  logic [255:0] hash_dout_a;
  logic [31:0]  hashes_done_a, hits_a;
  logic         hash_re_b, hash_rdy_b, target_loaded_b, result_valid_b, result_b, nonce_fifo_re_b;
  logic [255:0] hash_dout_b;
  logic [31:0]  hashes_done_b, hits_b;

  hash_target_comparator_p #(.HASH_W(256), .WORD_W(64), .TGT_W(32), .BYTE_SWAP(0)) dut_a (
    .clk(clk), .rst(rst), .target(target), .target_we(target_we), .stop(stop), .cmp_le(cmp_le),
    .hash_re(hash_re_a), .hash_din(hash_din), .hash_din_we(hash_din_we), .hash_dout(hash_dout_a),
    .hash_rdy(hash_rdy_a), .target_loaded(target_loaded_a), .result_valid(result_valid_a),
    .result(result_a), .nonce_fifo_re(nonce_fifo_re_a), .hashes_done(hashes_done_a), .hits(hits_a)
  );

  hash_target_comparator_p #(.HASH_W(256), .WORD_W(64), .TGT_W(32), .BYTE_SWAP(1)) dut_b (
    .clk(clk), .rst(rst), .target(target), .target_we(target_we), .stop(stop), .cmp_le(cmp_le),
    .hash_re(hash_re_b), .hash_din(hash_din), .hash_din_we(hash_din_we), .hash_dout(hash_dout_b),
    .hash_rdy(hash_rdy_b), .target_loaded(target_loaded_b), .result_valid(result_valid_b),
    .result(result_b), .nonce_fifo_re(nonce_fifo_re_b), .hashes_done(hashes_done_b), .hits(hits_b)
  );

  always #5 clk = ~clk;

  int unsigned  n_checks = 0;
  int unsigned  n_pass   = 0;
  logic [255:0] tgt_m;
  int unsigned  done_m, hits_a_m, hits_b_m;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [255:0] swap_words(input logic [255:0] h);
    logic [255:0] r;
    logic [63:0]  w, s;
    for (int i = 0; i < 4; i++) begin
      w = h[i*64 +: 64];
      s = {<<8{w}};
      r[i*64 +: 64] = s;
    end
    return r;
  endfunction

  task automatic reset_dut();
    rst = 1'b1; stop = 1'b0; target_we = 1'b0; hash_din_we = 1'b0; cmp_le = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hash_re", {hash_re_a, hash_re_b}, 0);
    check("rst_flags", {hash_rdy_a, target_loaded_a, result_valid_a, result_a, nonce_fifo_re_a,
                        hash_rdy_b, target_loaded_b, result_valid_b, result_b, nonce_fifo_re_b}, 0);
    check("rst_counters", {hashes_done_a, hits_a, hashes_done_b, hits_b}, 0);
    check("rst_hash_dout", hash_dout_a | hash_dout_b, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    done_m = 0; hits_a_m = 0; hits_b_m = 0;
  endtask

  task automatic load_target(input logic [255:0] t);
    for (int i = 0; i < 8; i++) begin
      target = t[i*32 +: 32];
      target_we = 1'b1;
      @(posedge clk); #1;
      if (i == 6) check("target_loaded_early", target_loaded_a, 0);
    end
    target_we = 1'b0;
    check("target_loaded", {target_loaded_a, target_loaded_b}, 2'b11);
    tgt_m = t;
  endtask

  task automatic send_hash(input logic [255:0] h, input int gap, input logic le);
    logic [255:0] hb;
    logic         hit_a, hit_b;
    hb    = swap_words(h);
    hit_a = le ? (h <= tgt_m) : (h < tgt_m);
    hit_b = le ? (hb <= tgt_m) : (hb < tgt_m);
    cmp_le = le;
    for (int i = 0; i < 4; i++) begin
      check("hash_re_collect", {hash_re_a, hash_re_b}, 2'b11);
      hash_din = h[i*64 +: 64];
      hash_din_we = 1'b1;
      @(posedge clk); #1;
      hash_din_we = 1'b0;
      if (i < 3) begin
        for (int g = 0; g < gap; g++) begin
          check("hash_re_gap", {hash_re_a, hash_re_b}, 2'b11);
          hash_din = 64'hDEAD_BEEF_0BAD_F00D;
          @(posedge clk); #1;
        end
      end
    end
    done_m++;
    check("result_not_early", {result_valid_a, result_valid_b}, 0);
    check("hash_re_result", {hash_re_a, hash_re_b}, 0);
    check("hash_rdy", {hash_rdy_a, hash_rdy_b}, 2'b11);
    check("hashes_done", {hashes_done_a, hashes_done_b}, {done_m, done_m});
    check("hash_dout_a", hash_dout_a, h);
    check("hash_dout_b", hash_dout_b, hb);
    @(posedge clk); #1;
    if (hit_a) hits_a_m++;
    if (hit_b) hits_b_m++;
    check("result_valid", {result_valid_a, result_valid_b, nonce_fifo_re_a, nonce_fifo_re_b}, 4'hF);
    check("result_a", result_a, hit_a);
    check("result_b", result_b, hit_b);
    check("hits", {hits_a, hits_b}, {hits_a_m, hits_b_m});
    @(posedge clk); #1;
    check("result_strobe_one_cycle", {result_valid_a, nonce_fifo_re_a, result_valid_b}, 0);
    check("result_held", {result_a, result_b}, {hit_a, hit_b});
  endtask

  task automatic stop_mid_hash();
    for (int i = 0; i < 2; i++) begin
      hash_din = {$urandom, $urandom};
      hash_din_we = 1'b1;
      @(posedge clk); #1;
    end
    hash_din_we = 1'b1;
    stop = 1'b1;
    #1;
    check("stop_hash_re", {hash_re_a, hash_re_b}, 0);
    @(posedge clk); #1;
    stop = 1'b0;
    hash_din_we = 1'b0;
    check("stop_no_result", {result_valid_a, nonce_fifo_re_a, result_valid_b}, 0);
    @(posedge clk); #1;
    done_m = 0; hits_a_m = 0; hits_b_m = 0;
    check("stop_counters", {hashes_done_a, hits_a, hashes_done_b, hits_b}, 0);
    check("stop_target_loaded", {target_loaded_a, target_loaded_b}, 0);
    for (int i = 0; i < 6; i++) begin
      hash_din = {$urandom, $urandom};
      hash_din_we = 1'b1;
      @(posedge clk); #1;
      check("unloaded_ignores_hash", {hash_re_a, result_valid_a, result_valid_b, hash_rdy_b}, 0);
    end
    hash_din_we = 1'b0;
    check("unloaded_done", {hashes_done_a, hashes_done_b}, 0);
  endtask

  initial begin
    logic [255:0] t, h;
    logic [63:0]  w;
    int           mode;

    reset_dut();
    t = 256'h1000;
    t = t << 224;
    load_target(t);
    send_hash({64'h00000FFF_FFFFFFFF, 64'h0, 64'h0, 64'h0}, 0, 1'b0);
    send_hash(t, 0, 1'b0);
    send_hash(t, 0, 1'b1);
    send_hash(t | 256'h1, 0, 1'b1);
    send_hash({64'h00000FFF_00000000, 64'h0, 64'h0, 64'h01000000_00000000}, 0, 1'b0);
    check("byte_swap_word0", hash_dout_b[63:0], 64'h00000000_00000001);
    send_hash({64'h00000FFF_FFFFFFFF, 64'h0, 64'h0, 64'h0}, 3, 1'b0);
    send_hash(t, 3, 1'b1);

    stop_mid_hash();
    load_target(t);
    send_hash({64'h00000000_12345678, 64'h0, 64'h0, 64'h5}, 1, 1'b0);

    // reset while a hash is half collected behaves like power-on
    hash_din = 64'h1;
    hash_din_we = 1'b1;
    @(posedge clk); #1;
    hash_din_we = 1'b0;
    reset_dut();

    for (int r = 0; r < 4; r++) begin
      if (r > 0) stop_mid_hash();
      t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      load_target(t);
      for (int n = 0; n < 10; n++) begin
        mode = $urandom_range(0, 4);
        case (mode)
          0: h = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
          1: h = t;
          2: begin w = {$urandom, $urandom}; h = t ^ {192'h0, w}; end
          3: h = swap_words(t);
          default: h = $urandom_range(0, 1) ? t + 256'd1 : t - 256'd1;
        endcase
        send_hash(h, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
